// File: rtl/spike_packet_scheduler.sv
// spike_packet_scheduler: buffers a 256-axon spike image and walks it, requesting synapse rows for spiking axons
// Ports: wb_clk_i/wb_rst_i clock and async reset; pkt_wr_i/pkt_new_i/pkt_last_i/pkt_data_i packet writes;
// axon_idx_o/row_req_o/row_ack_i synapse row handshake; acc_en_o/fire_o/spike_latch_o neuron strobes;
// busy_o run active, done_o sticky run complete, pkt_ovf_o sticky dropped packet.
module spike_packet_scheduler (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        pkt_wr_i,
  input  logic        pkt_new_i,
  input  logic        pkt_last_i,
  input  logic [31:0] pkt_data_i,
  output logic [7:0]  axon_idx_o,
  output logic        row_req_o,
  input  logic        row_ack_i,
  output logic        acc_en_o,
  output logic        fire_o,
  output logic        spike_latch_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pkt_ovf_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] ACC   = 3'd3;
  localparam logic [2:0] FIRE  = 3'd4;
  localparam logic [2:0] LATCH = 3'd5;
  logic [2:0]       r_state;
  logic [7:0][31:0] r_buf;
  logic [3:0]       r_wptr;
  logic [7:0]       r_idx;
  logic             r_done;
  logic             r_ovf;
  logic             w_bit;
  logic             w_end;
  assign w_bit = r_buf[r_idx[7:5]][r_idx[4:0]];
  assign w_end = r_idx == 8'hff;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_wptr  <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // any write outside IDLE is dropped and flagged
      if (pkt_wr_i && r_state != IDLE) r_ovf <= 1'b1;
      case (r_state)
        IDLE: if (pkt_wr_i) begin
          if (pkt_new_i) begin
            r_buf  <= {224'd0, pkt_data_i};
            r_wptr <= 4'd1;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
          end else if (r_wptr[3]) r_ovf <= 1'b1;
          else begin
            r_buf[r_wptr[2:0]] <= pkt_data_i;
            r_wptr <= r_wptr + 4'd1;
          end
          if (pkt_last_i) begin
            r_state <= SCAN;
            r_idx   <= '0;
          end
        end
        SCAN:
          if (w_bit) r_state <= REQ;
          else if (w_end) r_state <= FIRE;
          else r_idx <= r_idx + 8'd1;
        REQ: if (row_ack_i) r_state <= ACC;
        ACC:
          if (w_end) r_state <= FIRE;
          else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= SCAN;
          end
        FIRE: r_state <= LATCH;
        LATCH: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign axon_idx_o    = r_idx;
  assign row_req_o     = r_state == REQ;
  assign acc_en_o      = r_state == ACC;
  assign fire_o        = r_state == FIRE;
  assign spike_latch_o = r_state == LATCH;
  assign busy_o        = r_state != IDLE;
  assign done_o        = r_done;
  assign pkt_ovf_o     = r_ovf;
endmodule

// File: tb/tb_spike_packet_scheduler.sv
// tb_spike_packet_scheduler: directed self-checking bench for spike_packet_scheduler
module tb_spike_packet_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        nw = 1'b0;
  logic        lst = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  idx;
  logic        req, acc, fire, latch, busy, done, ovf;
  int n_cmp = 0;
  int n_err = 0;
  int scan_n, req_n, acc_n, fire_c, latch_c, done_c, first_idx;
  int acc_q[$];
  spike_packet_scheduler dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .pkt_wr_i(wr), .pkt_new_i(nw), .pkt_last_i(lst),
    .pkt_data_i(data), .axon_idx_o(idx), .row_req_o(req), .row_ack_i(ack),
    .acc_en_o(acc), .fire_o(fire), .spike_latch_o(latch), .busy_o(busy),
    .done_o(done), .pkt_ovf_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr_pkt(input logic n, input logic l, input logic [31:0] d);
    nw = n;
    lst = l;
    data = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    nw = 1'b0;
    lst = 1'b0;
    data = '0;
  endtask
  task automatic run(input int dly, input int wr_at);
    int run_len = 0;
    scan_n = 0; req_n = 0; acc_n = 0;
    fire_c = -1; latch_c = -1; done_c = -1; first_idx = -1;
    acc_q.delete();
    for (int c = 1; c <= 2000; c++) begin
      if (c == 1) first_idx = int'(idx);
      if (done) begin
        done_c = c;
        break;
      end
      if (busy && !req && !acc && !fire && !latch) scan_n++;
      if (req) req_n++;
      if (acc) begin
        acc_n++;
        acc_q.push_back(int'(idx));
      end
      if (fire && fire_c < 0) fire_c = c;
      if (latch && latch_c < 0) latch_c = c;
      run_len = req ? run_len + 1 : 0;
      ack = req && run_len > dly;
      if (c == wr_at) begin
        wr = 1'b1; nw = 1'b1; lst = 1'b1; data = '1;
      end
      @(negedge clk);
      ack = 1'b0; wr = 1'b0; nw = 1'b0; lst = 1'b0; data = '0;
    end
  endtask
  initial begin
    int bad;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_strobes", {req, acc, fire, latch}, 0);
    check("rst_idx", idx, 0);
    rst = 1'b0;
    @(negedge clk);
    wr_pkt(1, 1, 32'h0);
    run(0, -1);
    check("empty_first_idx", first_idx, 0);
    check("empty_scan", scan_n, 256);
    check("empty_req", req_n, 0);
    check("empty_fire", fire_c, 257);
    check("empty_latch", latch_c, 258);
    check("empty_done", done_c, 259);
    wr_pkt(1, 0, '1);
    repeat (6) wr_pkt(0, 0, '1);
    wr_pkt(0, 1, '1);
    check("full_done_cleared", done, 0);
    run(0, -1);
    check("full_req", req_n, 256);
    check("full_acc", acc_n, 256);
    bad = 0;
    foreach (acc_q[k]) if (acc_q[k] != k) bad++;
    check("full_idx_order", bad, 0);
    check("full_fire", fire_c, 769);
    check("full_done", done_c, 771);
    check("full_ovf", ovf, 0);
    wr_pkt(1, 0, 32'h8000_0001);
    repeat (6) wr_pkt(0, 0, 32'h0);
    wr_pkt(0, 1, 32'h8000_0000);
    run(3, 10);
    check("sparse_req", req_n, 12);
    check("sparse_acc", acc_n, 3);
    check("sparse_acc0", acc_q.size() > 0 ? acc_q[0] : -1, 0);
    check("sparse_acc1", acc_q.size() > 1 ? acc_q[1] : -1, 31);
    check("sparse_acc2", acc_q.size() > 2 ? acc_q[2] : -1, 255);
    check("sparse_fire", fire_c, 272);
    check("busy_wr_ovf", ovf, 1);
    wr_pkt(1, 0, 32'h1);
    for (int k = 1; k < 8; k++) wr_pkt(0, 0, 32'h1 << k);
    check("ovf_full_no_ovf", ovf, 0);
    check("ovf_full_idle", busy, 0);
    wr_pkt(0, 1, '1);
    check("ovf_drop_flag", ovf, 1);
    check("ovf_drop_busy", busy, 1);
    run(0, -1);
    check("ovf_acc", acc_n, 8);
    bad = 0;
    foreach (acc_q[k]) if (acc_q[k] != 33 * k) bad++;
    check("ovf_buf_unchanged", bad, 0);
    check("ovf_fire", fire_c, 273);
    check("ovf_sticky", ovf, 1);
    wr_pkt(1, 0, 32'h0);
    check("ovf_cleared", ovf, 0);
    check("done_cleared", done, 0);
    wr_pkt(0, 0, 32'h0);
    wr_pkt(0, 0, 32'h0);
    wr_pkt(0, 1, 32'h10);
    for (int c = 0; c < 300 && !req; c++) @(negedge clk);
    check("mid_req", req, 1);
    check("mid_idx", idx, 100);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {req, acc, fire, latch, done, ovf}, 0);
    check("mid_rst_idx", idx, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_pkt(0, 1, 32'h4);
    run(0, -1);
    check("post_first_idx", first_idx, 0);
    check("post_acc", acc_n, 1);
    check("post_acc_idx", acc_q.size() > 0 ? acc_q[0] : -1, 2);
    check("post_fire", fire_c, 259);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
